de1_soc_pll_rst_seq: RTL and testbench

Reset/lock sequencer for the board PLL. Runs on the free-running 50 MHz reference clock and drives the PLL reset. It qualifies the PLL locked signal and releases system reset only after lock has been stable. On loss of lock it re-sequences the PLL, and after repeated lock timeouts it parks in a fault state.

---
 rtl/de1_soc_pll_rst_seq.sv | 150 +++++++++++++++
 tb/tb_de1_soc_pll_rst_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/de1_soc_pll_rst_seq.sv
// PLL reset/lock sequencer: holds the PLL in reset, qualifies lock, releases system reset.
// Optional build macro PLL_RST_SEQ_GLITCH_FILTER_EN adds a 4-cycle loss-of-lock filter in RUN.
module de1_soc_pll_rst_seq #(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] relock_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Terminal counts: each is the last cycle spent in a state before it must move on.
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(3);
`endif

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_inc;
    logic [3:0]       retry_q, retry_nxt;
    logic [7:0]       relock_q, relock_nxt;
    logic [1:0]       sync_q;
    logic             locked_s;

    // pll_locked comes from the PLL's own domain; two flops before any decision uses it.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt  = state_q;
        cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_nxt    = cnt_inc;
        retry_nxt  = retry_q;
        relock_nxt = relock_q;

        if (soft_rst_req) begin
            state_nxt = ST_RESET_PLL;
            retry_nxt = '0;
        end else begin
            unique case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_nxt = retry_q + 4'd1;
                        state_nxt = (retry_nxt == RETRY_MAX) ? ST_FAULT : ST_RESET_PLL;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    retry_nxt = '0;
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
                    // In RUN the counter measures the current run of low locked_s cycles.
                    if (locked_s) begin
                        cnt_nxt = '0;
                    end else if (cnt_q == FILTER_LAST) begin
                        state_nxt  = ST_RESET_PLL;
                        relock_nxt = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                    end
`else
                    cnt_nxt = '0;
                    if (!locked_s) begin
                        state_nxt  = ST_RESET_PLL;
                        relock_nxt = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                    end
`endif
                end
                ST_FAULT: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = ST_RESET_PLL;
                end
            endcase
        end

        // Fresh count on every state entry, including a soft restart of RESET_PLL.
        if (soft_rst_req || (state_nxt != state_q)) begin
            cnt_nxt = '0;
        end
    end

    // Outputs decode the next state so they change on the same edge as state_q.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RESET_PLL;
            cnt_q    <= '0;
            retry_q  <= '0;
            relock_q <= '0;
            pll_rst  <= 1'b1;
            sys_rst  <= 1'b1;
            ready    <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            retry_q  <= retry_nxt;
            relock_q <= relock_nxt;
            pll_rst  <= (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAULT);
            sys_rst  <= (state_nxt != ST_RUN);
            ready    <= (state_nxt == ST_RUN);
            fault    <= (state_nxt == ST_FAULT);
        end
    end

    assign relock_cnt = relock_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_de1_soc_pll_rst_seq.sv
// Directed self-checking bench for de1_soc_pll_rst_seq (hold 4, stable 8, timeout 32, retries 2).
module tb_de1_soc_pll_rst_seq;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [7:0] relock_cnt;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    always #10 refclk = ~refclk;

    de1_soc_pll_rst_seq #(
        .RST_HOLD_CYCLES    (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES        (2),
        .CNT_W              (17)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .soft_rst_req(soft_rst_req),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fault       (fault),
        .relock_cnt  (relock_cnt),
        .state_o     (state_o)
    );

    // Advance n edges; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b0; soft_rst_req = 1'b0;
        tick(3);
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %b expected 1", sys_rst); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (relock_cnt !== 8'd0) begin errors++; $display("FAIL reset_relock: got %0d expected 0", relock_cnt); end
    endtask

    task automatic test_bringup();
        int n;
        rst = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n !== 4) begin errors++; $display("FAIL bringup_hold_cycles: got %0d expected 4", n); end
        tick(6);
        pll_locked = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n !== 11) begin errors++; $display("FAIL bringup_ready_latency: got %0d expected 11", n); end
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL bringup_sys_rst: got %b expected 0", sys_rst); end
        checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL bringup_state: got %0d expected 3", state_o); end
        checks++; if (relock_cnt !== 8'd0) begin errors++; $display("FAIL bringup_relock: got %0d expected 0", relock_cnt); end
    endtask

    task automatic test_timeout_fault();
        logic [2:0] exp;
        int bad;
        rst = 1'b1; pll_locked = 1'b0; tick(2); rst = 1'b0;
        for (int t = 1; t <= 72; t++) begin
            tick();
            exp = (t < 4) ? 3'd0 : (t < 36) ? 3'd1 : (t < 40) ? 3'd0 : (t < 72) ? 3'd1 : 3'd4;
            checks++;
            if (state_o !== exp) begin
                errors++; $display("FAIL timeout_state_t%0d: got %0d expected %0d", t, state_o, exp);
            end
        end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_flag: got %b expected 1", fault); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL fault_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL fault_sys_rst: got %b expected 1", sys_rst); end
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (state_o !== 3'd4 || fault !== 1'b1 || ready !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL fault_hold: %0d cycles left FAULT, expected 0", bad); end
    endtask

    task automatic test_soft_from_fault();
        soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0; pll_locked = 1'b1;
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL soft_exit_state: got %0d expected 0", state_o); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL soft_exit_fault: got %b expected 0", fault); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL soft_exit_pll_rst: got %b expected 1", pll_rst); end
        tick(4);
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL soft_wait_lock: got %0d expected 1", state_o); end
        tick();
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL soft_stable: got %0d expected 2", state_o); end
        tick(7);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL soft_ready_early: got %b expected 0", ready); end
        tick();
        checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL soft_run_state: got %0d expected 3", state_o); end
        checks++; if (ready !== 1'b1 || sys_rst !== 1'b0 || fault !== 1'b0) begin
            errors++; $display("FAIL soft_run_flags: got ready=%b sys_rst=%b fault=%b expected 1 0 0", ready, sys_rst, fault);
        end
    endtask

    task automatic test_run_glitch();
        int n;
        pll_locked = 1'b0; tick(); pll_locked = 1'b1;
        tick();
        checks++; if (state_o !== 3'd3 || sys_rst !== 1'b0) begin
            errors++; $display("FAIL glitch_pre: got state=%0d sys_rst=%b expected 3 0", state_o, sys_rst);
        end
        tick();
`ifdef PLL_RST_SEQ_GLITCH_FILTER_EN
        checks++; if (state_o !== 3'd3 || sys_rst !== 1'b0) begin
            errors++; $display("FAIL glitch_filtered: got state=%0d sys_rst=%b expected 3 0", state_o, sys_rst);
        end
        tick(20);
        checks++; if (ready !== 1'b1 || relock_cnt !== 8'd0) begin
            errors++; $display("FAIL glitch_ignored: got ready=%b relock=%0d expected 1 0", ready, relock_cnt);
        end
        pll_locked = 1'b0;
        tick(5);
        checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL filter_hold: got %0d expected 3", state_o); end
        tick();
        checks++; if (state_o !== 3'd0 || sys_rst !== 1'b1) begin
            errors++; $display("FAIL filter_trip: got state=%0d sys_rst=%b expected 0 1", state_o, sys_rst);
        end
        pll_locked = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n !== 13) begin errors++; $display("FAIL filter_reseq: got %0d expected 13", n); end
`else
        checks++; if (state_o !== 3'd0 || sys_rst !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL glitch_trip: got state=%0d sys_rst=%b ready=%b expected 0 1 0", state_o, sys_rst, ready);
        end
        tick(4);
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL glitch_wait_lock: got %0d expected 1", state_o); end
        tick(8);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL glitch_ready_early: got %b expected 0", ready); end
        tick();
        n = 1;
        checks++; if (ready !== 1'b1 || state_o !== 3'd3) begin
            errors++; $display("FAIL glitch_reseq: got ready=%b state=%0d expected 1 3 (n=%0d)", ready, state_o, n);
        end
`endif
        checks++; if (relock_cnt !== 8'd1) begin errors++; $display("FAIL glitch_relock: got %0d expected 1", relock_cnt); end
    endtask

    task automatic test_soft_vs_loss_then_async_reset();
        pll_locked = 1'b0; tick(2);
        soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0; pll_locked = 1'b1;
        checks++; if (state_o !== 3'd0 || sys_rst !== 1'b1) begin
            errors++; $display("FAIL softloss_state: got state=%0d sys_rst=%b expected 0 1", state_o, sys_rst);
        end
        checks++; if (relock_cnt !== 8'd1) begin errors++; $display("FAIL softloss_relock: got %0d expected 1", relock_cnt); end
        tick(5);
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL softloss_stable: got %0d expected 2", state_o); end
        tick(2);
        rst = 1'b1;
        #2;
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL async_state: got %0d expected 0", state_o); end
        checks++; if (pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0 || fault !== 1'b0) begin
            errors++; $display("FAIL async_flags: got pll_rst=%b sys_rst=%b ready=%b fault=%b expected 1 1 0 0", pll_rst, sys_rst, ready, fault);
        end
        checks++; if (relock_cnt !== 8'd0) begin errors++; $display("FAIL async_relock: got %0d expected 0", relock_cnt); end
        tick();
    endtask

    task automatic test_soft_in_reset_pll();
        rst = 1'b1; pll_locked = 1'b0; tick(2); rst = 1'b0;
        tick(2);
        soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
        tick(3);
        checks++; if (state_o !== 3'd0 || pll_rst !== 1'b1) begin
            errors++; $display("FAIL hold_restart: got state=%0d pll_rst=%b expected 0 1", state_o, pll_rst);
        end
        tick();
        checks++; if (state_o !== 3'd1 || pll_rst !== 1'b0) begin
            errors++; $display("FAIL hold_restart_exit: got state=%0d pll_rst=%b expected 1 0", state_o, pll_rst);
        end
    endtask

    task automatic test_stable_dropout();
        rst = 1'b1; pll_locked = 1'b1; tick(2); rst = 1'b0;
        tick(8);
        pll_locked = 1'b0; tick(); pll_locked = 1'b1;
        tick();
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL dropout_stable: got %0d expected 2", state_o); end
        tick();
        checks++; if (state_o !== 3'd1 || sys_rst !== 1'b1) begin
            errors++; $display("FAIL dropout_wait: got state=%0d sys_rst=%b expected 1 1", state_o, sys_rst);
        end
        tick();
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL dropout_restable: got %0d expected 2", state_o); end
        tick(7);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL dropout_ready_early: got %b expected 0", ready); end
        tick();
        checks++; if (ready !== 1'b1 || state_o !== 3'd3) begin
            errors++; $display("FAIL dropout_run: got ready=%b state=%0d expected 1 3", ready, state_o);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_timeout_fault();
        test_soft_from_fault();
        test_run_glitch();
        test_soft_vs_loss_then_async_reset();
        test_soft_in_reset_pll();
        test_stable_dropout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
